// File: rtl/imgproc_mm_arbiter.sv
// imgproc_mm_arbiter: round-robin arbiter sharing the image-processor Avalon-MM slave between two masters,
// spacing transactions so s_read is never high two cycles running.
module imgproc_mm_arbiter #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_chipselect,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_chipselect,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              s_chipselect,
  output logic              s_read,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata
);
  localparam int CW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, CMD, RESP, GAP} state_t;
  state_t state_q, state_d;
  logic s_chipselect_q, s_chipselect_d, s_read_q, s_read_d, s_write_q, s_write_d;
  logic [ADDR_W-1:0] s_address_q, s_address_d;
  logic [DATA_W-1:0] s_writedata_q, s_writedata_d;
  logic [DATA_W-1:0] m0_readdata_q, m0_readdata_d, m1_readdata_q, m1_readdata_d;
  logic m0_readdatavalid_q, m0_readdatavalid_d, m1_readdatavalid_q, m1_readdatavalid_d;
  logic last_grant_q, last_grant_d, grant_q, grant_d;
  logic [CW-1:0] gap_cnt_q, gap_cnt_d;
  logic req0, req1, gnt, accept;
  assign s_chipselect     = s_chipselect_q;
  assign s_read           = s_read_q;
  assign s_write          = s_write_q;
  assign s_address        = s_address_q;
  assign s_writedata      = s_writedata_q;
  assign m0_readdata      = m0_readdata_q;
  assign m1_readdata      = m1_readdata_q;
  assign m0_readdatavalid = m0_readdatavalid_q;
  assign m1_readdatavalid = m1_readdatavalid_q;
  assign req0   = m0_chipselect & (m0_read | m0_write);
  assign req1   = m1_chipselect & (m1_read | m1_write);
  assign gnt    = (req0 & req1) ? ~last_grant_q : req1;
  assign accept = (state_q == IDLE) & (req0 | req1);
  assign m0_waitrequest = ~(reset_n & accept & ~gnt);
  assign m1_waitrequest = ~(reset_n & accept & gnt);
  always_comb begin
    state_d            = state_q;
    s_chipselect_d     = 1'b0;
    s_read_d           = 1'b0;
    s_write_d          = 1'b0;
    s_address_d        = s_address_q;
    s_writedata_d      = s_writedata_q;
    m0_readdata_d      = m0_readdata_q;
    m1_readdata_d      = m1_readdata_q;
    m0_readdatavalid_d = 1'b0;
    m1_readdatavalid_d = 1'b0;
    last_grant_d       = last_grant_q;
    grant_d            = grant_q;
    gap_cnt_d          = gap_cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d        = CMD;
        s_chipselect_d = 1'b1;
        s_read_d       = gnt ? m1_read : m0_read;
        s_write_d      = ~s_read_d;
        s_address_d    = gnt ? m1_address : m0_address;
        s_writedata_d  = gnt ? m1_writedata : m0_writedata;
        last_grant_d   = gnt;
        grant_d        = gnt;
      end
      CMD: begin
        state_d   = s_read_q ? RESP : GAP;
        gap_cnt_d = CW'(GAP_CYCLES - 1);
      end
      RESP: begin
        m0_readdata_d      = grant_q ? m0_readdata_q : s_readdata;
        m1_readdata_d      = grant_q ? s_readdata : m1_readdata_q;
        m0_readdatavalid_d = ~grant_q;
        m1_readdatavalid_d = grant_q;
        state_d            = GAP;
      end
      default: begin
        state_d   = (gap_cnt_q == '0) ? IDLE : GAP;
        gap_cnt_d = (gap_cnt_q == '0) ? gap_cnt_q : gap_cnt_q - CW'(1);
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q            <= IDLE;
      s_chipselect_q     <= 1'b0;
      s_read_q           <= 1'b0;
      s_write_q          <= 1'b0;
      s_address_q        <= '0;
      s_writedata_q      <= '0;
      m0_readdata_q      <= '0;
      m1_readdata_q      <= '0;
      m0_readdatavalid_q <= 1'b0;
      m1_readdatavalid_q <= 1'b0;
      last_grant_q       <= 1'b1;
      grant_q            <= 1'b0;
      gap_cnt_q          <= '0;
    end else begin
      state_q            <= state_d;
      s_chipselect_q     <= s_chipselect_d;
      s_read_q           <= s_read_d;
      s_write_q          <= s_write_d;
      s_address_q        <= s_address_d;
      s_writedata_q      <= s_writedata_d;
      m0_readdata_q      <= m0_readdata_d;
      m1_readdata_q      <= m1_readdata_d;
      m0_readdatavalid_q <= m0_readdatavalid_d;
      m1_readdatavalid_q <= m1_readdatavalid_d;
      last_grant_q       <= last_grant_d;
      grant_q            <= grant_d;
      gap_cnt_q          <= gap_cnt_d;
    end
  end
endmodule

// File: tb/tb_imgproc_mm_arbiter.sv
// tb_imgproc_mm_arbiter: directed bench for the two-master image-processor arbiter,
// with a slave model whose READ_MSG register (addr 1) pops a counting FIFO.
module tb_imgproc_mm_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic        cs[3], rd[3], wr[3], wt[3], rdv[3];
  logic [2:0]  ad[3];
  logic [31:0] wd[3], rdd[3];
  logic        s_cs, s_rd, s_wr, t_cs, t_rd, t_wr, d_wt, d_rdv;
  logic [2:0]  s_ad, t_ad;
  logic [31:0] s_wd, t_wd, d_rdd, s_rdata = '0;
  logic [31:0] t_rdata = 32'h0;
  logic [15:0] msg_cnt = 16'd16;
  int cyc = 0, viol = 0, n_chk = 0, n_fail = 0;
  logic prev_st = 1'b0;
  int acc_m[$], acc_c[$], acc3[$], sw_c[$], sr_c[$], sr3[$], rv_m[$], rv_c[$];
  logic [31:0] sw_a[$], sw_d[$], rv_d[$];
  imgproc_mm_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_chipselect(cs[0]), .m0_read(rd[0]), .m0_write(wr[0]), .m0_address(ad[0]), .m0_writedata(wd[0]),
    .m0_waitrequest(wt[0]), .m0_readdata(rdd[0]), .m0_readdatavalid(rdv[0]),
    .m1_chipselect(cs[1]), .m1_read(rd[1]), .m1_write(wr[1]), .m1_address(ad[1]), .m1_writedata(wd[1]),
    .m1_waitrequest(wt[1]), .m1_readdata(rdd[1]), .m1_readdatavalid(rdv[1]),
    .s_chipselect(s_cs), .s_read(s_rd), .s_write(s_wr), .s_address(s_ad), .s_writedata(s_wd),
    .s_readdata(s_rdata)
  );
  imgproc_mm_arbiter #(.GAP_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .m0_chipselect(cs[2]), .m0_read(rd[2]), .m0_write(wr[2]), .m0_address(ad[2]), .m0_writedata(wd[2]),
    .m0_waitrequest(wt[2]), .m0_readdata(rdd[2]), .m0_readdatavalid(rdv[2]),
    .m1_chipselect(1'b0), .m1_read(1'b0), .m1_write(1'b0), .m1_address(3'd0), .m1_writedata(32'd0),
    .m1_waitrequest(d_wt), .m1_readdata(d_rdd), .m1_readdatavalid(d_rdv),
    .s_chipselect(t_cs), .s_read(t_rd), .s_write(t_wr), .s_address(t_ad), .s_writedata(t_wd),
    .s_readdata(t_rdata)
  );
  // Slave model: fixed read latency of one cycle; addr 1 pops a FIFO word tagged with the current count.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_rd) begin
      s_rdata <= (s_ad == 3'd1) ? {16'hC0DE, msg_cnt} : (32'h1234EEE0 | {29'd0, s_ad});
      if (s_ad == 3'd1) msg_cnt <= msg_cnt - 16'd1;
    end
  end
  always @(negedge clk) begin
    if (reset_n) begin
      for (int m = 0; m < 2; m++)
        if (cs[m] && (rd[m] || wr[m]) && !wt[m]) begin acc_m.push_back(m); acc_c.push_back(cyc); end
      if (cs[2] && !wt[2]) acc3.push_back(cyc);
    end
    if (s_wr) begin sw_c.push_back(cyc); sw_a.push_back({29'd0, s_ad}); sw_d.push_back(s_wd); end
    if (s_rd) sr_c.push_back(cyc);
    if (t_rd) sr3.push_back(cyc);
    for (int m = 0; m < 2; m++)
      if (rdv[m]) begin rv_m.push_back(m); rv_c.push_back(cyc); rv_d.push_back(rdd[m]); end
    if ((s_rd || s_wr) && prev_st) viol++;
    if ((t_rd || t_wr) && (t_cs === 1'b1) && (sr3.size() > 1) && (sr3[sr3.size()-2] == cyc - 1)) viol++;
    if (s_rd && s_wr) viol++;
    prev_st <= s_rd | s_wr;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    acc_m.delete(); acc_c.delete(); acc3.delete(); sw_c.delete(); sr_c.delete(); sr3.delete();
    rv_m.delete(); rv_c.delete(); sw_a.delete(); sw_d.delete(); rv_d.delete();
  endtask
  // Holds the request until accepted, then drops it just after the accepting edge.
  task automatic xact(input int m, input logic r, input logic [2:0] a, input logic [31:0] d);
    bit done = 1'b0;
    cs[m] = 1'b1; rd[m] = r; wr[m] = ~r; ad[m] = a; wd[m] = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!wt[m]) done = 1'b1;
      @(posedge clk); #1;
    end
    cs[m] = 1'b0; rd[m] = 1'b0; wr[m] = 1'b0;
    chk("accept", {31'd0, done}, 32'd1);
  endtask
  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask
  logic [15:0] c0;
  initial begin
    for (int i = 0; i < 3; i++) begin cs[i] = 0; rd[i] = 0; wr[i] = 0; ad[i] = 0; wd[i] = 0; end
    cs[0] = 1'b1; rd[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wait0", {31'd0, wt[0]}, 32'd1);
    chk("rst_strobes", {29'd0, s_cs, s_rd, s_wr}, 32'd0);
    chk("rst_saddr", {29'd0, s_ad}, 32'd0);
    chk("rst_rdv", {30'd0, rdv[0], rdv[1]}, 32'd0);
    chk("rst_rdata", rdd[0] | rdd[1], 32'd0);
    cs[0] = 1'b0; rd[0] = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    clr();
    xact(0, 1'b0, 3'd3, 32'h00FF00FF);
    repeat (4) @(posedge clk); #1;
    chk("t1_nacc", acc_m.size(), 1);
    chk("t1_gnt", acc_m[0], 0);
    chk("t1_nwr", sw_c.size(), 1);
    chk("t1_wr_cyc", sw_c[0], acc_c[0] + 1);
    chk("t1_addr", sw_a[0], 32'd3);
    chk("t1_wdata", sw_d[0], 32'h00FF00FF);
    chk("t1_nrdv", rv_c.size(), 0);
    clr();
    xact(1, 1'b1, 3'd2, 32'd0);
    repeat (5) @(posedge clk); #1;
    chk("t2_gnt", acc_m[0], 1);
    chk("t2_nrd", sr_c.size(), 1);
    chk("t2_rd_cyc", sr_c[0], acc_c[0] + 1);
    chk("t2_nrdv", rv_c.size(), 1);
    chk("t2_rdv_port", rv_m[0], 1);
    chk("t2_rdv_cyc", rv_c[0], acc_c[0] + 3);
    chk("t2_rdata", rv_d[0], 32'h1234EEE2);
    chk("t2_m0_quiet", rdd[0], 32'd0);
    pulse_reset();
    clr();
    c0 = msg_cnt;
    fork
      xact(0, 1'b1, 3'd1, 32'd0);
      xact(1, 1'b1, 3'd1, 32'd0);
    join
    repeat (5) @(posedge clk); #1;
    chk("t3_first", acc_m[0], 0);
    chk("t3_second", acc_m[1], 1);
    chk("t3_spacing", acc_c[1] - acc_c[0], 4);
    chk("t3_rdv0_port", rv_m[0], 0);
    chk("t3_word0", rv_d[0], {16'hC0DE, c0});
    chk("t3_word1", rv_d[1], {16'hC0DE, c0 - 16'd1});
    chk("t3_msg_drop", {16'd0, c0 - msg_cnt}, 32'd2);
    clr();
    fork
      for (int i = 0; i < 4; i++) xact(0, 1'b0, 3'd4, 32'h100 + i);
      for (int i = 0; i < 4; i++) xact(1, 1'b0, 3'd4, 32'h200 + i);
    join
    repeat (4) @(posedge clk); #1;
    chk("t4_nacc", acc_m.size(), 8);
    for (int i = 0; i < 8; i++) chk("t4_alt", acc_m[i], i % 2);
    chk("t4_nwr", sw_c.size(), 8);
    chk("t4_wdata_last", sw_d[7], 32'h203);
    chk("t4_spacing", acc_c[1] - acc_c[0], 3);
    clr();
    xact(0, 1'b1, 3'd2, 32'd0);
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_strobes", {29'd0, s_cs, s_rd, s_wr}, 32'd0);
    chk("t5_rdv", {31'd0, rdv[0]}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t5_no_rdv", rv_c.size(), 0);
    clr();
    fork
      xact(0, 1'b0, 3'd5, 32'd1);
      xact(1, 1'b0, 3'd5, 32'd2);
    join
    repeat (3) @(posedge clk); #1;
    chk("t5_tie_m0", acc_m[0], 0);
    clr();
    xact(2, 1'b1, 3'd2, 32'd0);
    xact(2, 1'b1, 3'd2, 32'd0);
    repeat (8) @(posedge clk); #1;
    chk("t6_nacc", acc3.size(), 2);
    chk("t6_spacing", acc3[1] - acc3[0], 6);
    chk("t6_nrd", sr3.size(), 2);
    chk("t6_rd0", sr3[0], acc3[0] + 1);
    chk("t6_rd1", sr3[1], acc3[1] + 1);
    chk("no_consec_strobe", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
